// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares a single TOP_uartTX among N_REQ producers. Each producer raises
//   req[i] with a DATA_W-bit word on its dato_in slice. A round-robin
//   scheduler picks one winner, latches its word onto Dato, pulses start,
//   waits for listo from the transmitter and then pulses ack to the winner.
//
// Optional feature (macro UART_ARB_TIMEOUT_EN):
//   Adds a WAIT-state watchdog. If listo does not arrive within TIMEOUT_CYC
//   cycles, the transaction is dropped: err pulses, gnt clears, no ack.
//   Without the macro err is tied 0 and WAIT waits forever.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   req      in   [N_REQ]         per-requester request level
//   dato_in  in   [N_REQ*DATA_W]  requester i word at [i*DATA_W +: DATA_W]
//   gnt      out  [N_REQ]         one-hot grant, grant cycle through ack cycle
//   ack      out  [N_REQ]         one-hot 1-cycle pulse, word fully sent
//   Dato     out  [DATA_W]        latched word to TOP_uartTX
//   start    out  1-cycle start pulse to TOP_uartTX
//   listo    in   1-cycle done pulse from TOP_uartTX
//   busy     out  high whenever the arbiter is not idle
//   err      out  1-cycle watchdog abort pulse (0 without the macro)
// ---------------------------------------------------------------------------

// Per-requester slice: decodes whether this lane is the round-robin winner
// or the current owner, and gates its word onto the shared OR-bus.
module uart_tx_arb_lane #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 2,
    parameter int LANE   = 0
) (
    input  logic [IDX_W-1:0]  win_i,
    input  logic [IDX_W-1:0]  cur_i,
    input  logic [DATA_W-1:0] word_i,
    output logic              win_hit_o,
    output logic              cur_hit_o,
    output logic [DATA_W-1:0] word_o
);
    assign win_hit_o = (win_i == IDX_W'(LANE));
    assign cur_hit_o = (cur_i == IDX_W'(LANE));
    assign word_o    = win_hit_o ? word_i : '0;
endmodule

module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] dato_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       Dato,
    output logic                    start,
    input  logic                    listo,
    output logic                    busy,
    output logic                    err
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [IDX_W-1:0]  idx_q, idx_d;     // current owner
    logic [IDX_W-1:0]  last_q, last_d;   // last served requester (rr pointer)
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  win;
    logic [IDX_W:0]    cand;
    logic [N_REQ-1:0]  win_oh;
    logic [N_REQ-1:0]  cur_oh;
    logic [DATA_W-1:0] win_word;
    logic [N_REQ-1:0][DATA_W-1:0] lane_word;

    // -----------------------------------------------------------------------
    // Round-robin search. Offsets are scanned from farthest to nearest so the
    // nearest set request after last_q overwrites the others and wins.
    // The one-bit-wider candidate absorbs last+offset before the wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        win  = last_q;
        cand = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                win = cand[IDX_W-1:0];
            end
        end
    end

    // Lane array: winner/owner decode and word select
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        uart_tx_arb_lane #(
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W),
            .LANE   (i)
        ) u_lane (
            .win_i     (win),
            .cur_i     (idx_q),
            .word_i    (dato_in[i*DATA_W +: DATA_W]),
            .win_hit_o (win_oh[i]),
            .cur_hit_o (cur_oh[i]),
            .word_o    (lane_word[i])
        );
    end

    always_comb begin
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_word = win_word | lane_word[i];
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`else
    // Watchdog limit has no effect in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        dato_d  = dato_q;
        start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // listo is ignored here; only a request moves us on.
                if (|req) begin
                    idx_d   = win;
                    dato_d  = win_word;
                    gnt_d   = win_oh;
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                // listo takes priority over a simultaneous watchdog expiry.
                if (listo) begin
                    ack_d   = cur_oh;
                    last_d  = idx_q;
                    state_d = DONE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abort: the stuck requester still counts as served so
                    // it cannot starve the others.
                    err_d   = 1'b1;
                    gnt_d   = '0;
                    last_d  = idx_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);   // requester 0 wins first
            gnt_q   <= '0;
            ack_q   <= '0;
            dato_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            dato_q  <= dato_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign Dato  = dato_q;
    assign start = start_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. A transaction-level model predicts the
// outputs each cycle; a single stimulus process compares the DUT against it
// at every falling edge and also checks hand-computed literal values.
// Define UART_ARB_TIMEOUT_EN to build with the watchdog (TIMEOUT_CYC=16).
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 2000000;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] dato_in;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [DW-1:0]   Dato;
    logic            start;
    logic            listo;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .dato_in (dato_in),
        .gnt     (gnt),
        .ack     (ack),
        .Dato    (Dato),
        .start   (start),
        .listo   (listo),
        .busy    (busy),
        .err     (err)
    );

    logic [DW-1:0] W [N];

    // ---------------- model ----------------
    int            m_ph;     // 0 idle, 1 start, 2 wait, 3 done
    int            m_own;
    int            m_last;
    int            m_wcnt;
    logic [N-1:0]  e_gnt, e_ack;
    logic [DW-1:0] e_dato;
    logic          e_start, e_busy, e_err;

    function automatic int rr_pick(input logic [N-1:0] r, input int lst);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = r >> ((lst + k) % N);
            if (sh[0]) return (lst + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        e_start = 1'b0;
        e_ack   = '0;
        e_err   = 1'b0;
        if (!reset) begin
            m_ph   = 0;
            m_last = N - 1;
            m_own  = 0;
            m_wcnt = 0;
            e_gnt  = '0;
            e_dato = '0;
        end else begin
            case (m_ph)
                0: if (req != '0) begin
                    m_own   = rr_pick(req, m_last);
                    e_dato  = W[m_own];
                    e_gnt   = N'(1) << m_own;
                    e_start = 1'b1;
                    m_ph    = 1;
                end
                1: begin
                    m_ph   = 2;
                    m_wcnt = 0;
                end
                2: begin
                    if (listo) begin
                        e_ack  = e_gnt;
                        m_last = m_own;
                        m_ph   = 3;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (m_wcnt == TO - 1) begin
                        e_err  = 1'b1;
                        e_gnt  = '0;
                        m_last = m_own;
                        m_ph   = 0;
                    end else begin
                        m_wcnt++;
                    end
`endif
                end
                default: begin
                    e_gnt = '0;
                    m_ph  = 0;
                end
            endcase
        end
        e_busy = (m_ph != 0);
    end

    // ---------------- bench state ----------------
    int           n_tests = 0;
    int           n_fail  = 0;
    int           ack_cnt = 0;
    int           lcnt    = 0;
    logic         auto_listo = 1'b0;
    logic         keep_req   = 1'b0;
    logic [N-1:0] rer        = '0;
    logic [N-1:0]  gnt_log [$];
    logic [DW-1:0] dato_log [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: compare against the model, log, then play the requesters
    // and the transmitter for the next edge.
    task automatic cyc();
        @(negedge clk);
        chk("gnt",   64'(gnt),   64'(e_gnt));
        chk("ack",   64'(ack),   64'(e_ack));
        chk("Dato",  64'(Dato),  64'(e_dato));
        chk("start", 64'(start), 64'(e_start));
        chk("busy",  64'(busy),  64'(e_busy));
        chk("err",   64'(err),   64'(e_err));
        if (start) begin
            gnt_log.push_back(gnt);
            dato_log.push_back(Dato);
        end
        if (ack != '0) ack_cnt++;
        if (auto_listo) begin
            listo = 1'b0;
            if (start) lcnt = 3;
            else if (lcnt > 0) begin
                lcnt--;
                if (lcnt == 0) listo = 1'b1;
            end
        end
        req = req | rer;
        rer = '0;
        if (ack != '0) begin
            req = req & ~ack;
            if (keep_req) rer = ack;
        end
    endtask

    task automatic run_acks(input int target, input int budget);
        int b = 0;
        while (ack_cnt < target && b < budget) begin
            cyc();
            b++;
        end
        chk("ack_count_within_budget", 64'(ack_cnt), 64'(target));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        gnt_log.delete();
        dato_log.delete();
        ack_cnt = 0;
        lcnt    = 0;
    endtask

    logic [N-1:0] fexp [8];
    int           fidx [8];

    initial begin
        reset   = 1'b0;
        req     = '0;
        listo   = 1'b0;
        W[0]    = 32'h484F4C41;
        W[1]    = 32'h11112222;
        W[2]    = 32'h33334444;
        W[3]    = 32'hA5A55A5A;
        dato_in = {W[3], W[2], W[1], W[0]};
        fexp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        fidx    = '{0, 1, 2, 3, 0, 1, 2, 3};

        // ---- reset state ----
        repeat (3) cyc();
        chk("rst_gnt",   64'(gnt),   64'h0);
        chk("rst_busy",  64'(busy),  64'h0);
        chk("rst_start", 64'(start), 64'h0);
        chk("rst_Dato",  64'(Dato),  64'h0);
        reset = 1'b1;
        cyc();

        // ---- single request ----
        req = 4'b0001;
        cyc();
        chk("single_start", 64'(start), 64'h1);
        chk("single_Dato",  64'(Dato),  64'h484F4C41);
        chk("single_gnt",   64'(gnt),   64'h1);
        cyc();
        chk("single_start_one_cycle", 64'(start), 64'h0);
        cyc();
        cyc();
        listo = 1'b1;
        cyc();
        chk("single_ack",      64'(ack),  64'h1);
        chk("single_busy_ack", 64'(busy), 64'h1);
        listo = 1'b0;
        cyc();
        chk("single_ack_clear", 64'(ack),  64'h0);
        chk("single_busy_low",  64'(busy), 64'h0);
        chk("single_gnt_clear", 64'(gnt),  64'h0);

        // ---- spurious listo in IDLE and START, req dropped in WAIT ----
        listo = 1'b1;
        cyc();
        chk("spur_idle_busy", 64'(busy), 64'h0);
        chk("spur_idle_ack",  64'(ack),  64'h0);
        listo = 1'b0;
        req   = 4'b0010;
        cyc();
        chk("spur_grant", 64'(gnt), 64'h2);
        listo = 1'b1;                // lands on the START edge
        cyc();
        chk("spur_start_ack",  64'(ack),  64'h0);
        chk("spur_start_busy", 64'(busy), 64'h1);
        listo = 1'b0;
        req   = '0;
        repeat (3) cyc();
        chk("spur_wait_gnt_hold", 64'(gnt),  64'h2);
        chk("spur_wait_dato",     64'(Dato), 64'h11112222);
        listo = 1'b1;
        cyc();
        chk("spur_drop_ack", 64'(ack), 64'h2);
        listo = 1'b0;
        cyc();

        // ---- simultaneous requests from reset ----
        pulse_reset();
        auto_listo = 1'b1;
        req = 4'b0110;
        run_acks(2, 60);
        repeat (2) cyc();
        chk("sim_count", 64'(gnt_log.size()), 64'd2);
        chk("sim_g0",    64'(gnt_log[0]),     64'h2);
        chk("sim_g1",    64'(gnt_log[1]),     64'h4);
        req = 4'b0010;
        run_acks(3, 60);
        repeat (2) cyc();
        chk("sim_g2", 64'(gnt_log[2]), 64'h2);

        // ---- fairness, all four requesting ----
        pulse_reset();
        keep_req = 1'b1;
        req = 4'b1111;
        run_acks(8, 300);
        keep_req = 1'b0;
        req = '0;
        rer = '0;
        repeat (3) cyc();
        chk("fair_count", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fair_gnt%0d", i),  64'(gnt_log[i]),  64'(fexp[i]));
            chk($sformatf("fair_dato%0d", i), 64'(dato_log[i]), 64'(W[fidx[i]]));
        end

        // ---- reset mid-WAIT restores the pointer ----
        auto_listo = 1'b0;
        listo = 1'b0;
        lcnt  = 0;
        req   = 4'b0010;         // served: pointer moves to 1
        cyc();
        cyc();
        listo = 1'b1;
        cyc();
        listo = 1'b0;
        cyc();
        req = 4'b0100;           // granted, then interrupted by reset
        cyc();
        chk("rw_pre_gnt", 64'(gnt), 64'h4);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        chk("rw_gnt",   64'(gnt),   64'h0);
        chk("rw_start", 64'(start), 64'h0);
        chk("rw_busy",  64'(busy),  64'h0);
        chk("rw_ack",   64'(ack),   64'h0);
        reset = 1'b1;
        // stale pointer (1) would pick requester 3; reset pointer picks 1
        req = 4'b1010;
        cyc();
        chk("rw_regrant", 64'(gnt),   64'h2);
        chk("rw_start2",  64'(start), 64'h1);
        req = 4'b1000;
        cyc();
        listo = 1'b1;
        cyc();
        chk("rw_ack2", 64'(ack), 64'h2);
        listo = 1'b0;
        req   = '0;
        repeat (3) cyc();

`ifdef UART_ARB_TIMEOUT_EN
        // ---- watchdog ----
        pulse_reset();
        req = 4'b0011;
        cyc();
        chk("to_gnt0", 64'(gnt), 64'h1);
        for (int j = 1; j <= 16; j++) cyc();
        chk("to_not_early", 64'(err), 64'h0);
        cyc();
        chk("to_err", 64'(err), 64'h1);
        chk("to_gnt", 64'(gnt), 64'h0);
        chk("to_ack", 64'(ack), 64'h0);
        cyc();
        chk("to_err_pulse", 64'(err),   64'h0);
        chk("to_next_gnt",  64'(gnt),   64'h2);
        chk("to_next_start",64'(start), 64'h1);
        req = '0;
        cyc();
        listo = 1'b1;
        cyc();
        listo = 1'b0;
        repeat (2) cyc();
`endif

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
